// File: rtl/harness_pkg.sv
// Shared types and the fixed command program replayed by chip_test_harness.
package harness_pkg;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    localparam int unsigned NUM_CMDS = 4;

    localparam logic [1:0] FAIL_NONE     = 2'd0;
    localparam logic [1:0] FAIL_MISMATCH = 2'd1;
    localparam logic [1:0] FAIL_TIMEOUT  = 2'd2;
    localparam logic [1:0] FAIL_ADC      = 2'd3;

    // Element 0 is the rightmost entry; reads expect the data of the preceding write.
    localparam cmd_t [NUM_CMDS-1:0] PROGRAM = {
        cmd_t'{op: OP_READ,  addr: 32'h0000_1004, data: 32'h1234_5678},
        cmd_t'{op: OP_WRITE, addr: 32'h0000_1004, data: 32'h1234_5678},
        cmd_t'{op: OP_READ,  addr: 32'h0000_1000, data: 32'hDEAD_BEEF},
        cmd_t'{op: OP_WRITE, addr: 32'h0000_1000, data: 32'hDEAD_BEEF}
    };

endpackage

// File: rtl/harness_adc_monitor.sv
// ADC sanity monitor: counts samples and records crossings of both thresholds.
module harness_adc_monitor
    import harness_pkg::*;
#(
    parameter int unsigned MIN_ADC = 64,
    parameter logic [7:0]  ADC_HI  = 8'hA0,
    parameter logic [7:0]  ADC_LO  = 8'h60
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       adc_valid,
    input  logic [7:0] adc_sample,
    output logic       adc_ok
);

    logic [7:0] count_q;
    logic       hi_seen_q;
    logic       lo_seen_q;

    // Saturating sample counter and sticky threshold-crossing flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q   <= 8'd0;
            hi_seen_q <= 1'b0;
            lo_seen_q <= 1'b0;
        end else if (adc_valid) begin
            if (count_q != 8'hFF) begin
                count_q <= count_q + 8'd1;
            end
            if (adc_sample > ADC_HI) begin
                hi_seen_q <= 1'b1;
            end
            if (adc_sample < ADC_LO) begin
                lo_seen_q <= 1'b1;
            end
        end
    end

    // The ADC check is met once enough samples arrived and both crossings were observed.
    always_comb begin
        adc_ok = (32'(count_q) >= MIN_ADC) && hi_seen_q && lo_seen_q;
    end

endmodule

// File: rtl/chip_test_harness.sv
// Replays the fixed serial command program into the chip and checks read responses.
// Optional ADC monitoring is enabled by defining ADC_MON_EN.
module chip_test_harness
    import harness_pkg::*;
#(
    parameter int unsigned W       = 32,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned MIN_ADC = 64,
    parameter logic [7:0]  ADC_HI  = 8'hA0,
    parameter logic [7:0]  ADC_LO  = 8'h60
) (
    input  logic         clock,
    input  logic         reset,
    output logic         tsi_out_valid,
    input  logic         tsi_out_ready,
    output logic [W-1:0] tsi_out_bits,
    input  logic         tsi_in_valid,
    output logic         tsi_in_ready,
    input  logic [W-1:0] tsi_in_bits,
    input  logic         adc_valid,
    input  logic [7:0]   adc_sample,
    output logic         io_success,
    output logic         io_failure,
    output logic [1:0]   fail_code,
    output logic [2:0]   cmd_idx
);

    localparam logic [3:0] StIdle    = 4'd0;
    localparam logic [3:0] StHdr     = 4'd1;
    localparam logic [3:0] StAddr    = 4'd2;
    localparam logic [3:0] StData    = 4'd3;
    localparam logic [3:0] StResp    = 4'd4;
    localparam logic [3:0] StNext    = 4'd5;
    localparam logic [3:0] StDone    = 4'd6;
    localparam logic [3:0] StFail    = 4'd7;
`ifdef ADC_MON_EN
    localparam logic [3:0] StAdcWait = 4'd8;
`endif

    localparam int unsigned TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

    logic [3:0]    state_q, state_d;
    logic [2:0]    cmd_idx_q, cmd_idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    fail_code_q, fail_code_d;
    cmd_t          cur_cmd;

    assign cur_cmd = PROGRAM[cmd_idx_q[1:0]];

`ifdef ADC_MON_EN
    logic adc_ok;

    harness_adc_monitor #(
        .MIN_ADC (MIN_ADC),
        .ADC_HI  (ADC_HI),
        .ADC_LO  (ADC_LO)
    ) u_adc_monitor (
        .clock      (clock),
        .reset      (reset),
        .adc_valid  (adc_valid),
        .adc_sample (adc_sample),
        .adc_ok     (adc_ok)
    );
`else
    logic unused_adc;
    assign unused_adc = ^{adc_valid, adc_sample, ADC_HI, ADC_LO, MIN_ADC[0]};
`endif

    // Next-state logic; outgoing words advance only on a valid&&ready cycle.
    always_comb begin
        state_d     = state_q;
        cmd_idx_d   = cmd_idx_q;
        tmo_d       = tmo_q;
        fail_code_d = fail_code_q;
        unique case (state_q)
            StIdle: state_d = StHdr;
            StHdr: begin
                if (tsi_out_ready) state_d = StAddr;
            end
            StAddr: begin
                if (tsi_out_ready) begin
                    state_d = (cur_cmd.op == OP_WRITE) ? StData : StResp;
                    tmo_d   = '0;
                end
            end
            StData: begin
                if (tsi_out_ready) state_d = StNext;
            end
            StResp: begin
                // A response arriving on the last counted cycle still wins over the timeout.
                if (tsi_in_valid) begin
                    if (tsi_in_bits == W'(cur_cmd.data)) begin
                        state_d = StNext;
                    end else begin
                        state_d     = StFail;
                        fail_code_d = FAIL_MISMATCH;
                    end
                end else if (tmo_q == TmoLast) begin
                    state_d     = StFail;
                    fail_code_d = FAIL_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StNext: begin
                cmd_idx_d = cmd_idx_q + 3'd1;
                if (cmd_idx_q == 3'(NUM_CMDS - 1)) begin
`ifdef ADC_MON_EN
                    state_d = StAdcWait;
                    tmo_d   = '0;
`else
                    state_d = StDone;
`endif
                end else begin
                    state_d = StHdr;
                end
            end
`ifdef ADC_MON_EN
            StAdcWait: begin
                if (adc_ok) begin
                    state_d = StDone;
                end else if (tmo_q == TmoLast) begin
                    state_d     = StFail;
                    fail_code_d = FAIL_ADC;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
`endif
            default: state_d = state_q;
        endcase
    end

    // State registers; reset aborts any transfer and restarts the program at command 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cmd_idx_q   <= 3'd0;
            tmo_q       <= '0;
            fail_code_q <= FAIL_NONE;
        end else begin
            state_q     <= state_d;
            cmd_idx_q   <= cmd_idx_d;
            tmo_q       <= tmo_d;
            fail_code_q <= fail_code_d;
        end
    end

    // Outputs decode the registered state only, so ready never feeds back into valid.
    always_comb begin
        tsi_out_bits = '0;
        unique case (state_q)
            StHdr:   tsi_out_bits[W-1] = cur_cmd.op;
            StAddr:  tsi_out_bits = W'(cur_cmd.addr);
            StData:  tsi_out_bits = W'(cur_cmd.data);
            default: tsi_out_bits = '0;
        endcase
        tsi_out_valid = (state_q == StHdr) || (state_q == StAddr) || (state_q == StData);
        tsi_in_ready  = (state_q == StResp);
        io_success    = (state_q == StDone);
        io_failure    = (state_q == StFail);
        fail_code     = fail_code_q;
        cmd_idx       = cmd_idx_q;
    end

endmodule

// File: tb/tb_chip_test_harness.sv
// Scoreboard bench for chip_test_harness with a small memory-model chip.
module tb_chip_test_harness;

    localparam int TIMEOUT = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tsi_out_valid;
    logic        tsi_out_ready = 1'b1;
    logic [31:0] tsi_out_bits;
    logic        tsi_in_valid = 1'b0;
    logic        tsi_in_ready;
    logic [31:0] tsi_in_bits = 32'd0;
    logic        adc_valid = 1'b0;
    logic [7:0]  adc_sample = 8'h80;
    logic        io_success;
    logic        io_failure;
    logic [1:0]  fail_code;
    logic [2:0]  cmd_idx;

    int checks   = 0;
    int failures = 0;

    // 0 always ready, 1 random ready, 2 corrupt read of 0x1004, 3 never respond
    int mode     = 0;
    // 1 sine-like ADC stream, 2 constant midscale
    int adc_mode = 1;

    logic [31:0] exp_q[$];
    logic [31:0] words [10] = '{
        32'h8000_0000, 32'h0000_1000, 32'hDEAD_BEEF,
        32'h0000_0000, 32'h0000_1000,
        32'h8000_0000, 32'h0000_1004, 32'h1234_5678,
        32'h0000_0000, 32'h0000_1004
    };
    logic [7:0] sine_tab [8] = '{8'h80, 8'hA2, 8'hB0, 8'hA2, 8'h80, 8'h5E, 8'h50, 8'h5E};

    chip_test_harness #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .tsi_out_valid (tsi_out_valid),
        .tsi_out_ready (tsi_out_ready),
        .tsi_out_bits  (tsi_out_bits),
        .tsi_in_valid  (tsi_in_valid),
        .tsi_in_ready  (tsi_in_ready),
        .tsi_in_bits   (tsi_in_bits),
        .adc_valid     (adc_valid),
        .adc_sample    (adc_sample),
        .io_success    (io_success),
        .io_failure    (io_failure),
        .fail_code     (fail_code),
        .cmd_idx       (cmd_idx)
    );

    initial forever #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: actual=no_finish required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every handshake pops one expected word.
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            check("exclusive_flags", 64'(io_success && io_failure), 64'd0);
            if (tsi_out_valid && tsi_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_word: actual=%h required=none", tsi_out_bits);
                end else begin
                    check("word", 64'(tsi_out_bits), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // Memory-model chip: handshakes captured at negedge, acted on just after posedge.
    logic        x_out, x_in, cur_op, resp_pend;
    logic [31:0] x_word, cur_addr;
    int          phase, resp_cnt, adc_idx;
    logic [31:0] mem [logic [31:0]];

    initial forever begin
        @(negedge clock);
        x_out  = !reset && tsi_out_valid && tsi_out_ready;
        x_in   = !reset && tsi_in_valid && tsi_in_ready;
        x_word = tsi_out_bits;
    end

    initial begin
        phase = 0; resp_pend = 1'b0; resp_cnt = 0; cur_op = 1'b0; cur_addr = '0;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                phase = 0;
                resp_pend = 1'b0;
                tsi_in_valid = 1'b0;
            end else begin
                if (x_in) tsi_in_valid = 1'b0;
                if (x_out) begin
                    case (phase)
                        0: begin cur_op = x_word[31]; phase = 1; end
                        1: begin
                            cur_addr = x_word;
                            if (cur_op) phase = 2;
                            else begin
                                phase = 0;
                                if (mode != 3) begin resp_pend = 1'b1; resp_cnt = 3; end
                            end
                        end
                        default: begin mem[cur_addr] = x_word; phase = 0; end
                    endcase
                end
                if (resp_pend) begin
                    resp_cnt--;
                    if (resp_cnt == 0) begin
                        resp_pend    = 1'b0;
                        tsi_in_valid = 1'b1;
                        tsi_in_bits  = mem[cur_addr] +
                                       ((mode == 2 && cur_addr == 32'h1004) ? 32'd1 : 32'd0);
                    end
                end
            end
            tsi_out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ADC stimulus: 100 samples after each reset release.
    initial begin
        adc_idx = 0;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                adc_idx = 0;
                adc_valid = 1'b0;
            end else if (adc_idx < 100) begin
                adc_valid  = 1'b1;
                adc_sample = (adc_mode == 1) ? sine_tab[adc_idx % 8] : 8'h80;
                adc_idx++;
            end else begin
                adc_valid = 1'b0;
            end
        end
    end

    task automatic check_reset(input string name);
        check(name, 64'({tsi_out_valid, tsi_in_ready, io_success, io_failure, fail_code, cmd_idx}),
              64'd0);
    endtask

    task automatic start_run(input int m, input int am);
        reset = 1'b1;
        mode = m;
        adc_mode = am;
        repeat (2) @(posedge clock);
        #1;
        check_reset("reset_outputs");
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(words[i]);
        @(negedge clock);
        #1 reset = 1'b0;
        #1 check("idle_first_cycle", 64'(tsi_out_valid), 64'd0);
        @(posedge clock);
        #1 check("hdr_after_idle", 64'(tsi_out_valid), 64'd1);
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(io_success || io_failure) && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!(io_success || io_failure)) begin
            checks++;
            failures++;
            $display("FAIL wait_end: actual=no_flag required=flag within %0d cycles", budget);
        end
    endtask

    initial begin
        int n;
        logic found;

        // 1: always-ready chip, latency 3
        start_run(0, 1);
        wait_end(3000);
        check("t1_success", 64'({io_success, io_failure}), 64'b10);
        check("t1_code_idx", 64'({fail_code, cmd_idx}), 64'({2'd0, 3'd4}));
        check("t1_all_words", 64'(exp_q.size()), 64'd0);

        // 2: random ready back-pressure
        start_run(1, 1);
        wait_end(3000);
        check("t2_success", 64'({io_success, io_failure}), 64'b10);
        check("t2_all_words", 64'(exp_q.size()), 64'd0);

        // 3: corrupt read of 0x1004
        start_run(2, 1);
        wait_end(3000);
        check("t3_flags", 64'({io_success, io_failure}), 64'b01);
        check("t3_code_idx", 64'({fail_code, cmd_idx}), 64'({2'd1, 3'd3}));
        repeat (5) @(posedge clock);
        #1 check("t3_sticky", 64'({io_success, io_failure}), 64'b01);

        // 4: no response to cmd 1; count cycles spent waiting in RESP
        start_run(3, 1);
        n = 0;
        for (int i = 0; i < 3000 && !io_failure; i++) begin
            @(negedge clock);
            if (tsi_in_ready) n++;
        end
        check("t4_flag", 64'({io_success, io_failure}), 64'b01);
        check("t4_resp_cycles", 64'(n), 64'(TIMEOUT));
        check("t4_code_idx", 64'({fail_code, cmd_idx}), 64'({2'd2, 3'd1}));
        check("t4_words_sent", 64'(exp_q.size()), 64'd5);

        // 5: reset while cmd 2 DATA word is presented
        start_run(0, 1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clock);
            #2;
            found = tsi_out_valid && (tsi_out_bits == 32'h1234_5678);
        end
        check("t5_reached_data", 64'(found), 64'd1);
        reset = 1'b1;
        #1 check_reset("t5_async_clear");
        check("t5_words_left", 64'(exp_q.size()), 64'd3);
        start_run(0, 1);
        wait_end(3000);
        check("t5_rerun", 64'({io_success, io_failure}), 64'b10);
        check("t5_rerun_words", 64'(exp_q.size()), 64'd0);

        // 6: constant midscale ADC stream
        start_run(0, 2);
        wait_end(3000);
`ifdef ADC_MON_EN
        check("t6_flags", 64'({io_success, io_failure}), 64'b01);
        check("t6_code", 64'(fail_code), 64'd3);
`else
        check("t6_flags", 64'({io_success, io_failure}), 64'b10);
        check("t6_code", 64'(fail_code), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
